// File: rtl/exec_controller.sv
// Execution sequencer: turns RUN/STEP/STOP/CLEAR commands into pipeline and PC
// clock enables, counts executed cycles, drains the pipeline on halt and watches for runaway runs.
module exec_controller #(
    parameter int                 DWORD      = 32,
    parameter int                 NB_DRAIN   = 4,
    parameter logic [DWORD-1:0]   MAX_CYCLES = {DWORD{1'b1}},
    parameter int                 NB_STATE   = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    input  logic                i_hlt,
    output logic                o_cmd_ready,
    output logic                o_pipeline_enable,
    output logic                o_pc_enable,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_cmd_err,
    output logic [DWORD-1:0]    o_cycle_count,
    output logic [NB_STATE-1:0] o_state
);

    localparam logic [NB_STATE-1:0] ST_IDLE   = NB_STATE'(0);
    localparam logic [NB_STATE-1:0] ST_RUN    = NB_STATE'(1);
    localparam logic [NB_STATE-1:0] ST_STEP   = NB_STATE'(2);
    localparam logic [NB_STATE-1:0] ST_DRAIN  = NB_STATE'(3);
    localparam logic [NB_STATE-1:0] ST_HALTED = NB_STATE'(4);

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [3:0]       DRAIN_INIT = 4'(NB_DRAIN);
    localparam logic [DWORD-1:0] CNT_MAX    = {DWORD{1'b1}};
    localparam logic [DWORD-1:0] RUN_LIMIT  = MAX_CYCLES - {{(DWORD-1){1'b0}}, 1'b1};

    logic [NB_STATE-1:0] state_q, state_d;
    logic [DWORD-1:0]    cnt_q, cnt_d;
    logic [3:0]          drain_q, drain_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cmd_fire;
    logic [DWORD-1:0]    cnt_inc;

    // Enables are decoded from registered state only, so they never glitch with inputs.
    assign o_pipeline_enable = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    assign o_pc_enable       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_busy            = o_pipeline_enable;
    assign o_cmd_ready       = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign o_done            = done_q;
    assign o_timeout         = timeout_q;
    assign o_cmd_err         = err_q;
    assign o_cycle_count     = cnt_q;
    assign o_state           = state_q;

    assign cmd_fire = i_cmd_valid && o_cmd_ready;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: begin
                            cnt_d     = '0;
                            timeout_d = 1'b0;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (cmd_fire && (i_cmd != CMD_STOP)) err_d = 1'b1;
                // Halt beats STOP, and STOP beats the watchdog.
                if (i_hlt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == RUN_LIMIT) begin
                    state_d   = ST_HALTED;
                    timeout_d = 1'b1;
                end
            end
            ST_STEP: begin
                cnt_d = cnt_inc;
                if (i_hlt) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= 4'd1) begin
                    state_d = ST_HALTED;
                    drain_d = 4'd0;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            ST_HALTED: begin
                if (cmd_fire) begin
                    if (i_cmd == CMD_CLEAR) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end else if (i_cmd != CMD_STOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            drain_q   <= 4'd0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed and random stimulus for exec_controller, checked cycle by cycle against
// a behavioural model of the command/halt rules.
module tb_exec_controller;

    localparam int DW   = 6;
    localparam int ND   = 4;
    localparam int MAXC = 16;
    localparam int CMAX = (1 << DW) - 1;

    localparam bit [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_STOP = 2'b10, C_CLR = 2'b11;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALT = 4;

    logic          clk = 1'b0;
    logic          i_reset, i_cmd_valid, i_hlt;
    logic [1:0]    i_cmd;
    logic          o_cmd_ready, o_pipeline_enable, o_pc_enable, o_busy;
    logic          o_done, o_timeout, o_cmd_err;
    logic [DW-1:0] o_cycle_count;
    logic [2:0]    o_state;

    int n_vec = 0, n_miss = 0;
    int m_st, m_cnt, m_drain;
    bit m_to, m_done, m_err;
    int pe_n, pc_n, done_n;

    always #5 clk = ~clk;

    exec_controller #(.DWORD(DW), .NB_DRAIN(ND), .MAX_CYCLES(6'(MAXC)), .NB_STATE(3)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .i_hlt(i_hlt), .o_cmd_ready(o_cmd_ready), .o_pipeline_enable(o_pipeline_enable),
        .o_pc_enable(o_pc_enable), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_cmd_err(o_cmd_err), .o_cycle_count(o_cycle_count), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the rules: what the controller should look like after this edge.
    task automatic model(input bit v, input bit [1:0] c, input bit h, input bit rn);
        int  prev;
        int  old;
        bit  acc;
        m_err = 1'b0;
        if (!rn) begin
            m_st = M_IDLE; m_cnt = 0; m_drain = 0; m_to = 1'b0; m_done = 1'b0;
            return;
        end
        prev = m_st;
        old  = m_cnt;
        acc  = v && (m_st == M_IDLE || m_st == M_RUN || m_st == M_HALT);
        if (m_st == M_RUN || m_st == M_STEP) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_st == M_IDLE) begin
            if (acc && c == C_RUN) m_st = M_RUN;
            else if (acc && c == C_STEP) m_st = M_STEP;
            else if (acc && c == C_CLR) begin m_cnt = 0; m_to = 1'b0; end
        end else if (m_st == M_RUN) begin
            m_err = acc && (c != C_STOP);
            if (h) begin m_st = M_DRAIN; m_drain = ND; end
            else if (acc && c == C_STOP) m_st = M_IDLE;
            else if (old == MAXC - 1) begin m_st = M_HALT; m_to = 1'b1; end
        end else if (m_st == M_STEP) begin
            if (h) begin m_st = M_DRAIN; m_drain = ND; end
            else m_st = M_IDLE;
        end else if (m_st == M_DRAIN) begin
            m_drain--;
            if (m_drain == 0) m_st = M_HALT;
        end else begin
            if (acc && c == C_CLR) begin m_st = M_IDLE; m_cnt = 0; m_to = 1'b0; end
            else if (acc && c != C_STOP) m_err = 1'b1;
        end
        m_done = (m_st == M_HALT) && (prev != M_HALT);
    endtask

    task automatic check_all();
        bit e_pe, e_pc, e_rdy;
        e_pe  = (m_st == M_RUN || m_st == M_STEP || m_st == M_DRAIN);
        e_pc  = (m_st == M_RUN || m_st == M_STEP);
        e_rdy = (m_st == M_IDLE || m_st == M_RUN || m_st == M_HALT);
        chk("state",   64'(o_state),           64'(m_st));
        chk("pipe_en", 64'(o_pipeline_enable), 64'(e_pe));
        chk("pc_en",   64'(o_pc_enable),       64'(e_pc));
        chk("busy",    64'(o_busy),            64'(e_pe));
        chk("ready",   64'(o_cmd_ready),       64'(e_rdy));
        chk("done",    64'(o_done),            64'(m_done));
        chk("timeout", 64'(o_timeout),         64'(m_to));
        chk("cmd_err", 64'(o_cmd_err),         64'(m_err));
        chk("count",   64'(o_cycle_count),     64'(m_cnt));
        pe_n   += int'(o_pipeline_enable === 1'b1);
        pc_n   += int'(o_pc_enable === 1'b1);
        done_n += int'(o_done === 1'b1);
    endtask

    task automatic tick(input bit v, input bit [1:0] c, input bit h, input bit rn = 1'b1);
        i_cmd_valid = v; i_cmd = c; i_hlt = h; i_reset = rn;
        @(posedge clk);
        model(v, c, h, rn);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, C_RUN, 1'b0);
    endtask

    task automatic clr_counts();
        pe_n = 0; pc_n = 0; done_n = 0;
    endtask

    initial begin
        i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_hlt = 1'b0;
        #1;

        for (int i = 0; i < 3; i++) tick(1'b0, C_RUN, 1'b0, 1'b0);
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_ready", 64'(o_cmd_ready), 64'd1);
        chk("rst_count", 64'(o_cycle_count), 64'd0);

        // RUN, halt in the 10th enabled cycle
        clr_counts();
        tick(1'b1, C_RUN, 1'b0);
        idle(9);
        tick(1'b0, C_RUN, 1'b1);
        idle(6);
        chk("halt_pe_cycles", 64'(pe_n), 64'd14);
        chk("halt_pc_cycles", 64'(pc_n), 64'd10);
        chk("halt_done_n",    64'(done_n), 64'd1);
        chk("halt_count",     64'(o_cycle_count), 64'd10);
        chk("halt_state",     64'(o_state), 64'd4);
        tick(1'b1, C_CLR, 1'b0);

        // three single steps
        clr_counts();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, C_STEP, 1'b0);
            chk("step_pe_now", 64'(o_pipeline_enable), 64'd1);
            idle(4);
        end
        chk("step_pe_cycles", 64'(pe_n), 64'd3);
        chk("step_count",     64'(o_cycle_count), 64'd3);
        chk("step_state",     64'(o_state), 64'd0);
        tick(1'b1, C_CLR, 1'b0);

        // STOP in cycle 7, then STOP together with halt
        tick(1'b1, C_RUN, 1'b0);
        idle(6);
        tick(1'b1, C_STOP, 1'b0);
        chk("stop_state", 64'(o_state), 64'd0);
        chk("stop_count", 64'(o_cycle_count), 64'd7);
        tick(1'b1, C_CLR, 1'b0);
        tick(1'b1, C_RUN, 1'b0);
        idle(6);
        tick(1'b1, C_STOP, 1'b1);
        chk("stophlt_state", 64'(o_state), 64'd3);
        idle(6);
        tick(1'b1, C_CLR, 1'b0);

        // watchdog
        clr_counts();
        tick(1'b1, C_RUN, 1'b0);
        idle(16);
        chk("wd_state",   64'(o_state), 64'd4);
        chk("wd_timeout", 64'(o_timeout), 64'd1);
        chk("wd_count",   64'(o_cycle_count), 64'd16);
        chk("wd_pe",      64'(pe_n), 64'd16);
        tick(1'b1, C_RUN, 1'b0);
        chk("wd_run_err", 64'(o_cmd_err), 64'd1);
        tick(1'b1, C_CLR, 1'b0);
        chk("wd_clr_state",   64'(o_state), 64'd0);
        chk("wd_clr_timeout", 64'(o_timeout), 64'd0);
        chk("wd_clr_count",   64'(o_cycle_count), 64'd0);

        // reset during DRAIN cycle 2
        tick(1'b1, C_RUN, 1'b0);
        idle(2);
        tick(1'b0, C_RUN, 1'b1);
        idle(1);
        clr_counts();
        tick(1'b0, C_RUN, 1'b0, 1'b0);
        chk("rstdr_state", 64'(o_state), 64'd0);
        chk("rstdr_pe",    64'(o_pipeline_enable), 64'd0);
        chk("rstdr_pc",    64'(o_pc_enable), 64'd0);
        idle(6);
        chk("rstdr_done_n", 64'(done_n), 64'd0);

        // STOP beats the watchdog at the limit; the counter then saturates
        tick(1'b1, C_RUN, 1'b0);
        idle(15);
        tick(1'b1, C_STOP, 1'b0);
        chk("prio_state",   64'(o_state), 64'd0);
        chk("prio_timeout", 64'(o_timeout), 64'd0);
        chk("prio_count",   64'(o_cycle_count), 64'd16);
        tick(1'b1, C_RUN, 1'b0);
        idle(60);
        chk("sat_count", 64'(o_cycle_count), 64'(CMAX));
        tick(1'b1, C_STOP, 1'b0);
        tick(1'b1, C_CLR, 1'b0);

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 60) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
